// File: rtl/poly_eval_pkg.sv
// Shared types and default sizing for the Horner polynomial evaluator.
package poly_eval_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_DEGREE = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_WAIT,
    S_CALC,
    S_DONE
  } state_t;

endpackage

// File: rtl/poly_mac.sv
// One Horner step: acc*x + coef truncated to WIDTH bits, with overflow flagged
// whenever any bit above WIDTH in the full-precision sum is set.
module poly_mac #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] coef,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam int WIDE = 2 * WIDTH + 1;

  logic [WIDE-1:0] full;

  assign full = WIDE'(acc) * WIDE'(x) + WIDE'(coef);
  assign sum  = full[WIDTH-1:0];
  assign ovf  = |full[WIDE-1:WIDTH];

endmodule

// File: rtl/poly_eval.sv
// Polynomial evaluator: operands arrive one per Go pulse (a_N .. a_0, then x),
// then p(x) is computed by Horner's rule, one multiply-add per clock.
module poly_eval
  import poly_eval_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEGREE = DEFAULT_DEGREE
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Go,
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] DataResult,
  output logic             ResultValid,
  output logic             Overflow
);

  localparam int IW    = $clog2(DEGREE + 2);
  // Array is padded to a power of two so idx can address it at full width.
  localparam int SLOTS = 1 << IW;
  localparam logic [IW-1:0] IDX_FIRST = IW'(DEGREE + 1);
  localparam logic [IW-1:0] IDX_TOP   = IW'(DEGREE);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);

  state_t           state_reg;
  logic [IW-1:0]    idx_reg;
  logic [WIDTH-1:0] coef_reg [SLOTS];
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] result_reg;
  logic             x_loaded_reg;
  logic             valid_reg;
  logic             ovf_reg;

  logic [IW-1:0]    idx_prev;
  logic [WIDTH-1:0] mac_coef;
  logic [WIDTH-1:0] mac_sum;
  logic             mac_ovf;

  // Slot idx holds a_(idx-1); idx == 0 selects the x operand during loading.
  assign idx_prev = idx_reg - IDX_ONE;
  assign mac_coef = coef_reg[idx_prev];

  poly_mac #(
    .WIDTH(WIDTH)
  ) u_mac (
    .acc (acc_reg),
    .x   (x_reg),
    .coef(mac_coef),
    .sum (mac_sum),
    .ovf (mac_ovf)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg    <= S_IDLE;
      idx_reg      <= IDX_FIRST;
      x_reg        <= '0;
      acc_reg      <= '0;
      result_reg   <= '0;
      x_loaded_reg <= 1'b0;
      valid_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        coef_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (Go) begin
            coef_reg[IDX_TOP] <= DataIn;
            idx_reg           <= IDX_TOP;
            x_loaded_reg      <= 1'b0;
            valid_reg         <= 1'b0;
            ovf_reg           <= 1'b0;
            state_reg         <= S_LOAD_WAIT;
          end
        end
        S_LOAD: begin
          if (Go) begin
            if (idx_reg == '0) begin
              x_reg        <= DataIn;
              x_loaded_reg <= 1'b1;
            end else begin
              coef_reg[idx_prev] <= DataIn;
              idx_reg            <= idx_prev;
            end
            state_reg <= S_LOAD_WAIT;
          end
        end
        S_LOAD_WAIT: begin
          // A capture only counts once Go has returned low.
          if (!Go) begin
            if (x_loaded_reg) begin
              acc_reg      <= coef_reg[IDX_TOP];
              idx_reg      <= IDX_TOP;
              x_loaded_reg <= 1'b0;
              state_reg    <= S_CALC;
            end else begin
              state_reg <= S_LOAD;
            end
          end
        end
        S_CALC: begin
          acc_reg <= mac_sum;
          if (mac_ovf) begin
            ovf_reg <= 1'b1;
          end
          if (idx_reg == IDX_ONE) begin
            result_reg <= mac_sum;
            valid_reg  <= 1'b1;
            idx_reg    <= IDX_FIRST;
            state_reg  <= S_DONE;
          end else begin
            idx_reg <= idx_prev;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign DataResult  = result_reg;
  assign ResultValid = valid_reg;
  assign Overflow    = ovf_reg;

endmodule

// File: tb/tb_poly_eval.sv
// Self-checking bench for poly_eval: a DEGREE=2 and a DEGREE=3 instance,
// directed scenarios plus random sequences against an arithmetic model.
module tb_poly_eval;

  logic       clk;
  logic       rst;
  logic       go2, go3;
  logic [7:0] din2, din3;
  logic [7:0] res2, res3;
  logic       vld2, vld3, ovf2, ovf3;

  int total = 0;
  int bad   = 0;
  int prev2 = 0;
  int prev3 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  poly_eval #(.WIDTH(8), .DEGREE(2)) dut2 (
    .Clock(clk), .Reset(rst), .Go(go2), .DataIn(din2),
    .DataResult(res2), .ResultValid(vld2), .Overflow(ovf2)
  );

  poly_eval #(.WIDTH(8), .DEGREE(3)) dut3 (
    .Clock(clk), .Reset(rst), .Go(go3), .DataIn(din3),
    .DataResult(res3), .ResultValid(vld3), .Overflow(ovf3)
  );

  function automatic int get_res(input bit d3);
    return d3 ? int'(res3) : int'(res2);
  endfunction

  function automatic bit get_vld(input bit d3);
    return d3 ? vld3 : vld2;
  endfunction

  function automatic bit get_ovf(input bit d3);
    return d3 ? ovf3 : ovf2;
  endfunction

  // Reference: p(x) as a sum of powers mod 256; overflow from the Horner
  // intermediates evaluated with unbounded integer arithmetic.
  function automatic void model(input int deg, input int a[4], input int x,
                                output int res, output bit ovf);
    longint p, acc, full;
    res = 0;
    p   = 1;
    for (int k = 0; k <= deg; k++) begin
      res = int'((longint'(res) + longint'(a[deg - k]) * p) % 256);
      p   = (p * x) % 256;
    end
    ovf = 1'b0;
    acc = a[0];
    for (int i = 1; i <= deg; i++) begin
      full = acc * x + a[i];
      if (full > 255) ovf = 1'b1;
      acc = full % 256;
    end
  endfunction

  task automatic drive(input bit d3, input bit g, input int v);
    if (d3) begin
      go3  = g;
      din3 = 8'(v);
    end else begin
      go2  = g;
      din2 = 8'(v);
    end
  endtask

  // Starts and ends on a falling edge; DataIn is scrambled while Go stays high.
  task automatic pulse(input bit d3, input int v, input int hold);
    drive(d3, 1'b1, v);
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      drive(d3, h < hold, int'($urandom_range(0, 255)));
    end
    @(negedge clk);
  endtask

  task automatic run_seq(input bit d3, input int a[4], input int x, input int hold,
                         input bit toggle, input string tag);
    int deg;
    int er;
    int prev;
    bit eo;
    deg  = d3 ? 3 : 2;
    prev = d3 ? prev3 : prev2;
    model(deg, a, x, er, eo);
    for (int i = 0; i <= deg; i++) begin
      pulse(d3, a[i], hold);
      if (i == 0) begin
        total++;
        if (get_vld(d3) !== 1'b0 || get_ovf(d3) !== 1'b0 || get_res(d3) !== prev) begin
          bad++;
          $display("FAIL %s first_capture valid=%0b ovf=%0b res=%0d required valid=0 ovf=0 res=%0d",
                   tag, get_vld(d3), get_ovf(d3), get_res(d3), prev);
        end
      end
    end
    pulse(d3, x, hold);
    if (toggle) drive(d3, 1'b1, int'($urandom_range(0, 255)));
    for (int c = 0; c <= deg; c++) begin
      if (c > 0) begin
        @(negedge clk);
        drive(d3, 1'b0, int'($urandom_range(0, 255)));
      end
      total++;
      if (c < deg) begin
        if (get_vld(d3) !== 1'b0 || get_res(d3) !== prev) begin
          bad++;
          $display("FAIL %s calc_cycle%0d valid=%0b res=%0d required valid=0 res=%0d",
                   tag, c, get_vld(d3), get_res(d3), prev);
        end
      end else begin
        if (get_vld(d3) !== 1'b1 || get_res(d3) !== er || get_ovf(d3) !== eo) begin
          bad++;
          $display("FAIL %s result valid=%0b res=%0d ovf=%0b required valid=1 res=%0d ovf=%0b",
                   tag, get_vld(d3), get_res(d3), get_ovf(d3), er, eo);
        end
      end
    end
    if (d3) prev3 = er;
    else prev2 = er;
    $display("seq %s deg=%0d x=%0d hold=%0d toggle=%0b -> res=%0d ovf=%0b",
             tag, deg, x, hold, toggle, get_res(d3), get_ovf(d3));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 0);
    repeat (3) @(negedge clk);
    total++;
    if (res2 !== 8'd0 || vld2 !== 1'b0 || ovf2 !== 1'b0 ||
        res3 !== 8'd0 || vld3 !== 1'b0 || ovf3 !== 1'b0) begin
      bad++;
      $display("FAIL reset_state res2=%0d vld2=%0b ovf2=%0b res3=%0d vld3=%0b ovf3=%0b required all 0",
               res2, vld2, ovf2, res3, vld3, ovf3);
    end
    rst = 1'b0;
    @(negedge clk);
    prev2 = 0;
    prev3 = 0;
    $display("reset: outputs res2=%0d res3=%0d", res2, res3);
  endtask

  task automatic test_basic();
    run_seq(1'b0, '{2, 3, 1, 0}, 4, 1, 1'b0, "basic_45");
  endtask

  task automatic test_overflow();
    run_seq(1'b1, '{1, 0, 0, 0}, 7, 1, 1'b0, "cube_ovf");
  endtask

  task automatic test_hold_and_toggle();
    run_seq(1'b0, '{2, 3, 1, 0}, 4, 10, 1'b1, "hold10_toggle");
  endtask

  task automatic test_back_to_back();
    run_seq(1'b0, '{1, 1, 1, 0}, 2, 1, 1'b0, "b2b_7");
    run_seq(1'b1, '{0, 0, 2, 3}, 5, 2, 1'b0, "b2b_ovf_clear");
  endtask

  task automatic test_zero_cases();
    run_seq(1'b0, '{int'($urandom_range(1, 255)), int'($urandom_range(1, 255)), 77, 0}, 0, 1, 1'b0, "x_zero");
    run_seq(1'b1, '{0, 0, 0, 0}, int'($urandom_range(1, 255)), 1, 1'b0, "coef_zero");
  endtask

  task automatic test_async_reset();
    // Leave dut3 partway through loading; the reset must abandon it.
    run_seq(1'b1, '{1, 0, 0, 0}, 7, 1, 1'b0, "pre_reset_ovf");
    pulse(1'b1, 9, 1);
    pulse(1'b1, 9, 1);
    pulse(1'b0, 2, 1);
    pulse(1'b0, 3, 1);
    pulse(1'b0, 1, 1);
    pulse(1'b0, 4, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (res2 !== 8'd0 || vld2 !== 1'b0 || ovf2 !== 1'b0 ||
        res3 !== 8'd0 || vld3 !== 1'b0 || ovf3 !== 1'b0) begin
      bad++;
      $display("FAIL async_reset res2=%0d vld2=%0b ovf2=%0b res3=%0d vld3=%0b ovf3=%0b required all 0",
               res2, vld2, ovf2, res3, vld3, ovf3);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    prev2 = 0;
    prev3 = 0;
    $display("async reset: outputs cleared res2=%0d res3=%0d", res2, res3);
    run_seq(1'b0, '{0, 0, 5, 0}, 9, 1, 1'b0, "after_reset_5");
    run_seq(1'b1, '{3, 1, 4, 1}, 5, 1, 1'b0, "after_midload_reset");
  endtask

  task automatic test_random();
    int a[4];
    bit d3;
    for (int n = 0; n < 20; n++) begin
      d3 = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        a[k] = (n < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
      end
      run_seq(d3, a, int'($urandom_range(0, 255)), int'($urandom_range(1, 3)),
              1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    go2  = 1'b0;
    go3  = 1'b0;
    din2 = '0;
    din3 = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_hold_and_toggle();
    test_back_to_back();
    test_zero_cases();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
